pool_map_writer: RTL and testbench

Write-side counterpart of the clocked pooling engine. It accepts the stream of pooled results, one per window in row-major window order, and stores them as a compacted output feature map in an internal buffer. It reports completion when the last window of the configured image has been written. A synchronous read port lets the next CNN layer fetch the map.

---
 rtl/pool_map_writer.sv | 146 ++++++++++++++
 tb/tb_pool_map_writer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pool_map_writer.sv
// Pooled-result map writer: stores one pooled value per window, in row-major order, into a compact buffer.
// Latency: a beat is written in its accept cycle; done is high 1 cycle after the last accept; rd_data is ready 1 cycle after rd_addr.
// Backpressure: in_ready is high only in FILL, so the writer takes 1 beat/cycle and in_valid gaps just stall it.
//
// Ports:
//   clk, reset (async, active-low)
//   start, imgSize, windowSize        : begin a frame (configuration sampled on start)
//   in_valid, in_data, in_ready       : pooled-value stream (valid/ready)
//   rd_addr, rd_data                  : synchronous read port, 1-cycle latency, live in all states
//   busy, done, count, cfg_err        : frame status
// Build option: define POOL_WR_RELU_EN to clamp negative values to 0 on store.
module pool_map_writer #(
  parameter int N     = 32,
  parameter int DW    = 16,
  parameter int DEPTH = N * N,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [15:0]          imgSize,
  input  logic [15:0]          windowSize,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  output logic                 in_ready,
  input  logic [AW-1:0]        rd_addr,
  output logic signed [DW-1:0] rd_data,
  output logic                 busy,
  output logic                 done,
  output logic [AW:0]          count,
  output logic                 cfg_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} state_t;

  localparam logic [15:0]   S_MAX   = 16'(N);
  localparam logic [15:0]   W_MAX   = 16'd5;   // largest window the pooling engine supports
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  state_t              state, state_nxt;
  logic [15:0]         s_reg, w_reg;
  logic [15:0]         col_px, row_px;
  logic [AW-1:0]       wr_ptr;
  logic                cfg_ok;
  logic                accept;
  logic                last_beat;
  logic [16:0]         col_sum, row_sum;
  logic                col_wrap, row_wrap;
  logic signed [DW-1:0] wr_val;
  logic [DW-1:0]       mem [DEPTH];

  assign cfg_ok = (imgSize != 16'd0) && (imgSize <= S_MAX) &&
                  (windowSize != 16'd0) && (windowSize <= W_MAX);

  // Wrap rule is "next position >= S", which counts partial edge windows
  // and yields a ceil(S/W) x ceil(S/W) grid. 17-bit sums avoid overflow.
  assign col_sum  = {1'b0, col_px} + {1'b0, w_reg};
  assign row_sum  = {1'b0, row_px} + {1'b0, w_reg};
  assign col_wrap = (col_sum >= {1'b0, s_reg});
  assign row_wrap = (row_sum >= {1'b0, s_reg});

`ifdef POOL_WR_RELU_EN
  assign wr_val = in_data[DW-1] ? '0 : in_data;
`else
  assign wr_val = in_data;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = (state != ST_IDLE);
    done      = 1'b0;
    accept    = 1'b0;
    last_beat = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && cfg_ok) state_nxt = ST_FILL;
      end
      ST_FILL: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && col_wrap && row_wrap) begin
          last_beat = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Configuration, pointers and status. start is only honoured in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_reg   <= '0;
      w_reg   <= '0;
      col_px  <= '0;
      row_px  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      cfg_err <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      if (cfg_ok) begin
        s_reg   <= imgSize;
        w_reg   <= windowSize;
        col_px  <= '0;
        row_px  <= '0;
        wr_ptr  <= '0;
        count   <= '0;
        cfg_err <= 1'b0;
      end else begin
        cfg_err <= 1'b1;
      end
    end else if (accept) begin
      wr_ptr <= wr_ptr + PTR_ONE;
      count  <= count + CNT_ONE;
      if (col_wrap) begin
        col_px <= '0;
        row_px <= row_sum[15:0];
      end else begin
        col_px <= col_sum[15:0];
      end
    end
  end

  // Buffer storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= wr_val;
  end

  // A same-cycle read of the address being written returns the old word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_pool_map_writer.sv
// Self-checking bench for pool_map_writer: directed frames plus randomized frames against a behavioural model.
// Latency expectations: done 1 cycle after the last accept, rd_data 1 cycle after rd_addr.
// Backpressure: the bench inserts in_valid gaps and checks that count only advances on accepted beats.
module tb_pool_map_writer;

  logic               clk;
  logic               reset;
  logic               start;
  logic [15:0]        imgSize;
  logic [15:0]        windowSize;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               in_ready;
  logic [9:0]         rd_addr;
  logic signed [15:0] rd_data;
  logic               busy;
  logic               done;
  logic [10:0]        count;
  logic               cfg_err;

  int n_vec = 0;
  int n_err = 0;

  logic signed [15:0] exp_mem [1024];
  int                 tbl [4];

  pool_map_writer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .imgSize    (imgSize),
    .windowSize (windowSize),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .count      (count),
    .cfg_err    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Value the buffer should hold after storing v.
  function automatic logic signed [15:0] stored(input logic signed [15:0] v);
`ifdef POOL_WR_RELU_EN
    return (v < 0) ? 16'sd0 : v;
`else
    return v;
`endif
  endfunction

  // gap_mode: 0 back-to-back, 1 in_valid low every other cycle, 2 random gaps.
  task automatic run_frame(input int s, input int w, input int gap_mode,
                           input bit mid_start, input bit use_tbl);
    int n;
    int gaps;
    logic signed [15:0] v;
    n = ((s + w - 1) / w) * ((s + w - 1) / w);
    @(negedge clk);
    start = 1'b1; imgSize = 16'(s); windowSize = 16'(w);
    @(negedge clk);
    start = 1'b0;
    chk("busy_on", busy, 1);
    chk("rdy_on", in_ready, 1);
    chk("cnt_clr", count, 0);
    chk("cfgerr_clr", cfg_err, 0);
    for (int i = 0; i < n; i++) begin
      gaps = (gap_mode == 1) ? ((i > 0) ? 1 : 0) :
             (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < gaps; g++) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        @(negedge clk);
        chk("gap_cnt", count, i);
        chk("gap_done_lo", done, 0);
      end
      v = use_tbl ? 16'(tbl[i]) : 16'($urandom);
      exp_mem[i] = stored(v);
      in_valid = 1'b1;
      in_data  = v;
      if (mid_start && i == n / 2) begin
        // Ignored mid-frame; an invalid config also must not raise cfg_err.
        start = 1'b1; imgSize = 16'd0; windowSize = 16'd0;
      end
      chk("fill_done_lo", done, 0);
      chk("fill_cnt", count, i);
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b0;
    chk("done_hi", done, 1);
    chk("rdy_lo_done", in_ready, 0);
    chk("busy_in_done", busy, 1);
    chk("cnt_total", count, n);
    if (mid_start) chk("cfgerr_mid", cfg_err, 0);
    @(negedge clk);
    chk("done_pulse_end", done, 0);
    chk("busy_off", busy, 0);
    chk("cnt_hold", count, n);
    for (int a = 0; a < n; a++) begin
      rd_addr = 10'(a);
      @(negedge clk);
      chk("rd_word", rd_data, exp_mem[a]);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; imgSize = '0; windowSize = '0;
    in_valid = 1'b0; in_data = '0; rd_addr = '0;
    #1;
    chk("rst_rdy", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", count, 0);
    chk("rst_cfgerr", cfg_err, 0);
    chk("rst_rd", rd_data, 0);
    @(negedge clk);
    reset = 1'b1;

    // in_valid while idle is ignored.
    in_valid = 1'b1; in_data = 16'sd99;
    @(negedge clk);
    in_valid = 1'b0;
    chk("idle_ignore_cnt", count, 0);
    chk("idle_rdy", in_ready, 0);

    tbl = '{10, 20, 30, 40};
    run_frame(4, 2, 0, 1'b0, 1'b1);
    run_frame(5, 2, 1, 1'b0, 1'b0);

    // Rejected configurations.
    @(negedge clk);
    start = 1'b1; imgSize = 16'd4; windowSize = 16'd0;
    @(negedge clk);
    start = 1'b0;
    chk("w0_cfgerr", cfg_err, 1);
    chk("w0_busy", busy, 0);
    start = 1'b1; imgSize = 16'd33; windowSize = 16'd2;
    @(negedge clk);
    start = 1'b0;
    chk("s33_cfgerr", cfg_err, 1);
    chk("s33_busy", busy, 0);
    @(negedge clk);
    chk("cfgerr_sticky", cfg_err, 1);
    run_frame(4, 4, 0, 1'b0, 1'b0);
    run_frame(3, 5, 0, 1'b0, 1'b0);

    // Negative and positive values through the store path.
    tbl = '{-5, 7, 1, -1};
    run_frame(2, 1, 0, 1'b0, 1'b1);

    // Reset mid-frame after 2 of 4 beats.
    @(negedge clk);
    start = 1'b1; imgSize = 16'd4; windowSize = 16'd2;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 16'sd1;
    @(negedge clk);
    in_data = 16'sd2;
    @(negedge clk);
    chk("pre_rst_cnt", count, 2);
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cnt", count, 0);
    chk("mid_rst_rdy", in_ready, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_done", done, 0);
    chk("post_rst_busy", busy, 0);
    run_frame(4, 2, 0, 1'b0, 1'b0);

    // start pulsed mid-FILL.
    run_frame(6, 2, 2, 1'b1, 1'b0);

    // Randomized frames across the legal configuration space.
    for (int f = 0; f < 8; f++) begin
      run_frame(int'($urandom_range(1, 32)), int'($urandom_range(1, 5)),
                int'($urandom_range(0, 2)), f[0], 1'b0);
    end
    run_frame(32, 1, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
